// File: rtl/ifetch_pkg.sv
// Shared constants and types for the instruction fetch stage.
package ifetch_pkg;

  localparam int unsigned INS_W     = 32;
  localparam int unsigned OPCODE_HI = 31;
  localparam int unsigned OPCODE_LO = 26;
  localparam int unsigned OPCODE_W  = OPCODE_HI - OPCODE_LO + 1;

  localparam logic [OPCODE_W-1:0] OP_BR   = 6'b100000;
  localparam logic [OPCODE_W-1:0] OP_CALL = 6'b100001;
  localparam logic [OPCODE_W-1:0] OP_RET  = 6'b100010;
  localparam logic [OPCODE_W-1:0] OP_HALT = 6'b100100;
  localparam logic [OPCODE_W-1:0] OP_NOP  = 6'b100101;

  localparam logic [INS_W-1:0] NOP_WORD = 32'h94000000;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } fetch_state_e;

  // True when the word carries the HALT opcode.
  function automatic logic is_halt(input logic [INS_W-1:0] word);
    return word[OPCODE_HI:OPCODE_LO] == OP_HALT;
  endfunction

endpackage

// File: rtl/ifetch_skid_buf.sv
// One-entry skid buffer holding a fetched {word, pc} pair while the decoder stalls.
module ifetch_skid_buf
  import ifetch_pkg::*;
#(
  parameter int unsigned PC_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [INS_W-1:0] word_i,
  input  logic [PC_W-1:0]  pc_i,
  output logic             valid_o,
  output logic [INS_W-1:0] word_o,
  output logic [PC_W-1:0]  pc_o
);

  logic             valid_q, valid_d;
  logic [INS_W-1:0] word_q, word_d;
  logic [PC_W-1:0]  pc_q, pc_d;

  // Flush beats push beats pop; push and pop never coincide in the fetch stage.
  always_comb begin
    valid_d = valid_q;
    word_d  = word_q;
    pc_d    = pc_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (push_i) begin
      valid_d = 1'b1;
      word_d  = word_i;
      pc_d    = pc_i;
    end else if (pop_i) begin
      valid_d = 1'b0;
    end
  end

  // Buffer registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      word_q  <= '0;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      word_q  <= word_d;
      pc_q    <= pc_d;
    end
  end

  assign valid_o = valid_q;
  assign word_o  = word_q;
  assign pc_o    = pc_q;

endmodule

// File: rtl/ifetch_stage.sv
// Instruction fetch stage: PC, 1-cycle-latency imem issue, registered output
// with stall handshake, redirect and HALT stop.
// Optional performance counters are built when IFETCH_PERF_EN is defined.
module ifetch_stage
  import ifetch_pkg::*;
#(
  parameter int unsigned     PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int unsigned     PC_STEP  = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             stall_i,
  input  logic             redirect_valid_i,
  input  logic [PC_W-1:0]  redirect_pc_i,
  output logic             imem_en_o,
  output logic [PC_W-1:0]  imem_addr_o,
  input  logic [INS_W-1:0] imem_rdata_i,
  output logic [INS_W-1:0] ins_o,
  output logic             ins_valid_o,
  output logic [PC_W-1:0]  pc_out_o,
  output logic             halted_o
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0]      fetch_cnt_o,
  output logic [31:0]      stall_cnt_o
`endif
);

  localparam logic [PC_W-1:0] PC_INC = PC_W'(PC_STEP);

  fetch_state_e     state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic             infl_q, infl_d;
  logic [PC_W-1:0]  infl_pc_q, infl_pc_d;
  logic [INS_W-1:0] ins_q, ins_d;
  logic [PC_W-1:0]  pc_out_q, pc_out_d;
  logic             ins_valid_q, ins_valid_d;
  logic             issue_c;

  logic             skid_push, skid_pop, skid_flush;
  logic             skid_valid;
  logic [INS_W-1:0] skid_word;
  logic [PC_W-1:0]  skid_pc;

  ifetch_skid_buf #(
    .PC_W (PC_W)
  ) u_skid (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (skid_flush),
    .push_i  (skid_push),
    .pop_i   (skid_pop),
    .word_i  (imem_rdata_i),
    .pc_i    (infl_pc_q),
    .valid_o (skid_valid),
    .word_o  (skid_word),
    .pc_o    (skid_pc)
  );

  // Next-state: redirect overrides everything, then issue and capture/skid steering.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    infl_d      = 1'b0;
    infl_pc_d   = infl_pc_q;
    ins_d       = ins_q;
    pc_out_d    = pc_out_q;
    ins_valid_d = ins_valid_q;
    skid_push   = 1'b0;
    skid_pop    = 1'b0;
    skid_flush  = 1'b0;
    issue_c     = 1'b0;

    if (redirect_valid_i) begin
      pc_d        = redirect_pc_i;
      ins_valid_d = 1'b0;
      skid_flush  = 1'b1;
      state_d     = ST_RUN;
    end else begin
      issue_c = (state_q == ST_RUN) && !stall_i && !skid_valid;
      if (issue_c) begin
        pc_d      = pc_q + PC_INC;
        infl_d    = 1'b1;
        infl_pc_d = pc_q;
      end

      if (!stall_i) begin
        // Output is free or being consumed: skid entry first, then the returning word.
        if (skid_valid) begin
          ins_d       = skid_word;
          pc_out_d    = skid_pc;
          ins_valid_d = 1'b1;
          skid_pop    = 1'b1;
          if (is_halt(skid_word)) state_d = ST_HALTED;
        end else if (infl_q && (state_q == ST_RUN)) begin
          ins_d       = imem_rdata_i;
          pc_out_d    = infl_pc_q;
          ins_valid_d = 1'b1;
          if (is_halt(imem_rdata_i)) state_d = ST_HALTED;
        end else begin
          ins_valid_d = 1'b0;
        end
      end else if (infl_q && (state_q == ST_RUN)) begin
        // Output held: park the single word still returning from memory.
        skid_push = 1'b1;
      end
      // Words returning after HALT are dropped by the RUN qualifier above.
    end
  end

  // Pipeline and FSM state registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_RUN;
      pc_q        <= RESET_PC;
      infl_q      <= 1'b0;
      infl_pc_q   <= '0;
      ins_q       <= NOP_WORD;
      pc_out_q    <= '0;
      ins_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      infl_q      <= infl_d;
      infl_pc_q   <= infl_pc_d;
      ins_q       <= ins_d;
      pc_out_q    <= pc_out_d;
      ins_valid_q <= ins_valid_d;
    end
  end

  // Memory request is combinational so the read lands in the following cycle.
  assign imem_en_o   = issue_c && !rst_i;
  assign imem_addr_o = pc_q;
  assign ins_o       = ins_q;
  assign ins_valid_o = ins_valid_q;
  assign pc_out_o    = pc_out_q;
  assign halted_o    = (state_q == ST_HALTED);

`ifdef IFETCH_PERF_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Saturating delivery and stalled-output counters; redirect does not touch them.
  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (ins_valid_q && !stall_i && (fetch_cnt_q != 32'hFFFF_FFFF)) fetch_cnt_d = fetch_cnt_q + 32'd1;
    if (ins_valid_q && stall_i && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  // Counter registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign fetch_cnt_o = fetch_cnt_q;
  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: doc/ifetch_stage.md
Name: ifetch_stage

Overview:
- Instruction fetch stage directly upstream of the instruction decoder.
- Holds the PC and issues word addresses to a synchronous instruction memory with 1-cycle read latency.
- Registers the returned 32-bit instruction and its PC for the decoder, with a downstream stall handshake and a redirect input from branch/CALL resolution.
- Stops fetching after delivering a HALT instruction.

Parameters:
- PC_W, 32, width of PC and memory address.
- RESET_PC, 0, PC value loaded on reset.
- PC_STEP, 1, PC increment per fetched instruction (word addressing).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  decoder cannot accept; current output must be held.
- redirect_valid  in  1  one-cycle pulse: resume fetch at redirect_pc.
- redirect_pc  in  PC_W  target PC for the redirect.
- imem_en  out  1  read request this cycle.
- imem_addr  out  PC_W  read address, equal to the current PC.
- imem_rdata  in  32  instruction word, valid the cycle after imem_en.
- ins  out  32  instruction to the decoder.
- ins_valid  out  1  ins/pc_out hold a live instruction.
- pc_out  out  PC_W  address of ins.
- halted  out  1  fetch stopped on HALT.

Behaviour:
- Reset values:
  - pc = RESET_PC; ins = NOP word 32'h94000000; pc_out = 0.
  - ins_valid = 0, imem_en = 0, halted = 0.
  - Skid buffer empty; in-flight flag clear; FSM = RUN.
  - Reset mid-operation discards all in-flight and buffered data.
- FSM states: RUN, HALTED.
  - RUN -> HALTED when a word whose bits [31:26] = 6'b100100 is captured into the output register.
  - HALTED -> RUN only on redirect_valid or rst.
- Issue (RUN only):
  - imem_en = !stall && skid buffer empty && !redirect_valid.
  - imem_addr = pc.
  - When imem_en = 1: pc <= pc + PC_STEP (modulo 2^PC_W; wrap from all-ones to 0 is legal); in-flight flag set with the issued PC.
- Capture (cycle after issue): the returned word goes to ins/pc_out with ins_valid = 1 if the output register is free or being consumed (!stall); otherwise it goes to the 1-entry skid buffer.
- Stall:
  - While stall = 1, ins, pc_out and ins_valid hold exactly.
  - At most one further word arrives and is stored in the skid buffer; no new issue.
  - On stall deassertion the skid entry moves to the output first, then issue resumes.
  - Throughput: 1 instruction/cycle when stall = 0.
- Latency: fetch-to-ins_valid is 2 cycles after reset release or redirect (issue cycle + capture edge).
- Redirect (priority over stall and halt):
  - On redirect_valid: pc <= redirect_pc; in-flight word discarded; skid buffer cleared; ins_valid <= 0; halted <= 0; FSM <= RUN.
  - Issue at redirect_pc happens the following cycle.
- HALT:
  - The HALT word itself is delivered with ins_valid = 1.
  - The word fetched after it (in flight or in the skid buffer) is discarded.
  - halted = 1 from the cycle the HALT is captured; imem_en = 0 while halted.
  - ins_valid drops to 0 once the HALT is accepted (stall = 0).
- Simultaneous stall + redirect: redirect wins; output invalidated regardless of stall.

Optional Feature:
- Macro IFETCH_PERF_EN.
- When defined, adds two outputs:
  - fetch_cnt (32): count of instructions delivered (ins_valid && !stall).
  - stall_cnt (32): count of cycles with ins_valid && stall.
- Both counters reset to 0 on rst, saturate at 32'hFFFFFFFF, and are unaffected by redirect.
- When undefined, the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package:
  - Opcode constants (HALT = 6'b100100, NOP = 6'b100101, BR, CALL, etc.).
  - NOP_WORD = 32'h94000000.
  - OPCODE_HI = 31, OPCODE_LO = 26.
  - FSM state encoding (RUN, HALTED).
- Sub-module: ifetch_skid_buf, a 1-entry buffer holding {word, pc} with valid, push, pop and flush.

Test Plan:
- Reset release, memory word[i] = i, stall = 0 -> imem_addr 0,1,2…; ins_valid first high 2 cycles after reset; pc_out/ins = 0/0, 1/1, 2/2 on consecutive cycles.
- Stall for 3 cycles while ins = word 4 -> ins/pc_out hold 4 for 3 cycles; no issue; after release, 5 then 6 delivered with no loss or duplication.
- Redirect to 0x40 while stalled with the skid buffer full -> next cycle ins_valid = 0; imem_addr = 0x40 the cycle after; the first delivered pc_out is 0x40.
- Word 3 = 32'h90000000 (HALT) -> HALT delivered at pc_out = 3; word 4 never delivered; halted = 1; imem_en stays 0 for 20 cycles; a redirect to 0 restarts fetch.
- RESET_PC = 32'hFFFFFFFF -> pc_out sequence FFFFFFFF, 00000000, 00000001.
- Assert rst mid-stream with stall = 1 -> next cycle all outputs at reset values; fetch restarts at RESET_PC.
